// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet transmit path.
// Address map, control register layout and FSM state encodings.
package eth_pkg;

    localparam logic [15:0] BUF_BASE_DEF    = 16'hF000;
    localparam logic [15:0] CR_ADDR_DEF     = 16'hFB00;
    localparam logic [15:0] TX_RST_ADDR_DEF = 16'hFB01;

    localparam int BUF_SIZE        = 1024;
    localparam int BUF_AW          = 10;
    localparam int LEN_W           = 11;
    localparam int CR_TX_N_RDY_BIT = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT
    } tx_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACC,
        BUS_DONE
    } bus_state_e;

    function automatic logic [7:0] cr_value(input logic busy);
        logic [7:0] v;
        v = 8'h00;
        v[CR_TX_N_RDY_BIT] = busy;
        return v;
    endfunction

endpackage

// File: rtl/eth_tx_shifter.sv
// Byte serialiser: shifts a loaded byte out LSB first with its own
// serial clock, and pulses done on the last falling edge.
module eth_tx_shifter #(
    parameter int SCK_HALF = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       done_o
);

    localparam int CW = $clog2(SCK_HALF + 1);

    logic          active_q, active_d;
    logic          high_q, high_d;
    logic          pend_q, pend_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          done_q, done_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Phase timing: low/high halves counted from the edge that starts
    // them; the next data bit is presented one clock after each fall.
    always_comb begin
        active_d = active_q;
        high_d   = high_q;
        pend_d   = pend_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        done_d   = 1'b0;
        sr_d     = sr_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            active_d = 1'b1;
            high_d   = 1'b0;
            pend_d   = 1'b0;
            sck_d    = 1'b0;
            mosi_d   = data_i[0];
            sr_d     = data_i;
            bit_d    = 3'd0;
            cnt_d    = CW'(1);
        end else if (active_q) begin
            if (pend_q) begin
                pend_d = 1'b0;
                sr_d   = sr_q >> 1;
                mosi_d = sr_q[1];
            end
            if (cnt_q == CW'(SCK_HALF)) begin
                cnt_d = CW'(1);
                if (!high_q) begin
                    high_d = 1'b1;
                    sck_d  = 1'b1;
                end else begin
                    high_d = 1'b0;
                    sck_d  = 1'b0;
                    if (bit_q == 3'd7) begin
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        pend_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Shifter state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active_q <= 1'b0;
            high_q   <= 1'b0;
            pend_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
            sr_q     <= 8'h00;
            bit_q    <= 3'd0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            high_q   <= high_d;
            pend_q   <= pend_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            done_q   <= done_d;
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;
    assign done_o = done_q;

endmodule

// File: rtl/eth_transmitter.sv
// CPU-mapped Ethernet transmit path: frame buffer, control register,
// start strobe and the fetch/serialise FSM driving the serial link.
module eth_transmitter
    import eth_pkg::*;
#(
    parameter int          SCK_HALF    = 2,
    parameter logic [15:0] BUF_BASE    = BUF_BASE_DEF,
    parameter logic [15:0] CR_ADDR     = CR_ADDR_DEF,
    parameter logic [15:0] TX_RST_ADDR = TX_RST_ADDR_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] a,
    inout  wire  [7:0]  d,
    input  logic        n_we,
    input  logic        n_oe,
    output logic        n_rdy,
    output logic        tx_sck,
    output logic        tx_mosi
);

    logic        we, oe, strobe;
    logic [15:0] a_off;
    logic [9:0]  off;
    logic        sel_buf, sel_cr, sel_st;
    logic        cpu_go, cpu_buf, start, busy;

    bus_state_e  bus_q, bus_d;
    logic        n_rdy_q, n_rdy_d;
    logic        drv_q, drv_d;
    logic [7:0]  dout_q, dout_d;
    logic        rd_q, rd_d;
    logic        rd_cr_q, rd_cr_d;
    logic        rd_buf_q, rd_buf_d;

    tx_state_e        tx_q, tx_d;
    logic [LEN_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0] flen_q, flen_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] off1;
    logic             ld_q, ld_d;
    logic             fetch;

    logic [7:0]        mem [BUF_SIZE];
    logic [7:0]        ram_q;
    logic              ram_we, ram_re;
    logic [BUF_AW-1:0] ram_addr;

    logic sh_done;

    assign we      = ~n_we;
    assign oe      = ~n_oe;
    assign strobe  = we | oe;
    assign a_off   = a - BUF_BASE;
    assign off     = a_off[9:0];
    assign off1    = {1'b0, off} + LEN_W'(1);
    assign sel_buf = (a >= BUF_BASE) && (a_off < 16'(BUF_SIZE));
    assign sel_cr  = (a == CR_ADDR);
    assign sel_st  = (a == TX_RST_ADDR);
    assign cpu_go  = (bus_q == BUS_IDLE) && strobe
                   && (sel_buf || sel_cr || sel_st);
    assign cpu_buf = cpu_go && sel_buf;
    assign busy    = (tx_q != TX_IDLE);
    assign start   = cpu_go && we && sel_st
                   && !busy && (len_q != '0);

    assign ram_addr = cpu_buf ? off : ptr_q[BUF_AW-1:0];
    assign ram_we   = cpu_buf && we;
    assign ram_re   = cpu_buf ? !we : fetch;

    // Single-port frame buffer; the CPU port wins the address mux.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= d;
        end
        if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    // Bus handshake: act on the first sampled strobe, then hold n_rdy
    // low until both strobes are released.
    always_comb begin
        bus_d    = bus_q;
        n_rdy_d  = n_rdy_q;
        drv_d    = drv_q;
        dout_d   = dout_q;
        rd_d     = rd_q;
        rd_cr_d  = rd_cr_q;
        rd_buf_d = rd_buf_q;
        unique case (bus_q)
            BUS_IDLE: begin
                if (cpu_go) begin
                    bus_d    = BUS_ACC;
                    rd_d     = !we;
                    rd_cr_d  = sel_cr;
                    rd_buf_d = sel_buf;
                end
            end
            BUS_ACC: begin
                bus_d   = BUS_DONE;
                n_rdy_d = 1'b0;
                if (rd_q) begin
                    drv_d = 1'b1;
                    if (rd_cr_q) begin
                        dout_d = cr_value(busy);
                    end else if (rd_buf_q) begin
                        dout_d = ram_q;
                    end else begin
                        dout_d = 8'h00;
                    end
                end
            end
            BUS_DONE: begin
                if (!strobe) begin
                    bus_d   = BUS_IDLE;
                    n_rdy_d = 1'b1;
                    drv_d   = 1'b0;
                end
            end
            default: bus_d = BUS_IDLE;
        endcase
    end

    // Transmit FSM with length tracking; a fetch blocked by a CPU
    // buffer access simply stays in LOAD and retries.
    always_comb begin
        tx_d   = tx_q;
        ptr_d  = ptr_q;
        flen_d = flen_q;
        len_d  = len_q;
        ld_d   = 1'b0;
        fetch  = 1'b0;
        if (cpu_buf && we && (off1 > len_q)) begin
            len_d = off1;
        end
        unique case (tx_q)
            TX_IDLE: begin
                if (start) begin
                    tx_d   = TX_LOAD;
                    flen_d = len_q;
                    len_d  = '0;
                    ptr_d  = '0;
                end
            end
            TX_LOAD: begin
                if (!cpu_buf) begin
                    fetch = 1'b1;
                    ptr_d = ptr_q + LEN_W'(1);
                    ld_d  = 1'b1;
                    tx_d  = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (sh_done) begin
                    tx_d = (ptr_q == flen_q) ? TX_IDLE : TX_LOAD;
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    // Bus and transmit state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus_q    <= BUS_IDLE;
            n_rdy_q  <= 1'b1;
            drv_q    <= 1'b0;
            dout_q   <= 8'h00;
            rd_q     <= 1'b0;
            rd_cr_q  <= 1'b0;
            rd_buf_q <= 1'b0;
            tx_q     <= TX_IDLE;
            ptr_q    <= '0;
            flen_q   <= '0;
            len_q    <= '0;
            ld_q     <= 1'b0;
        end else begin
            bus_q    <= bus_d;
            n_rdy_q  <= n_rdy_d;
            drv_q    <= drv_d;
            dout_q   <= dout_d;
            rd_q     <= rd_d;
            rd_cr_q  <= rd_cr_d;
            rd_buf_q <= rd_buf_d;
            tx_q     <= tx_d;
            ptr_q    <= ptr_d;
            flen_q   <= flen_d;
            len_q    <= len_d;
            ld_q     <= ld_d;
        end
    end

    eth_tx_shifter #(
        .SCK_HALF (SCK_HALF)
    ) u_shifter (
        .clk    (clk),
        .n_rst  (n_rst),
        .load_i (ld_q),
        .data_i (ram_q),
        .sck_o  (tx_sck),
        .mosi_o (tx_mosi),
        .done_o (sh_done)
    );

    assign n_rdy = n_rdy_q;
    assign d     = drv_q ? dout_q : 8'bz;

endmodule

// File: tb/tb_eth_transmitter.sv
// Bench for eth_transmitter: CPU bus tasks feed a scoreboard of
// expected serial bytes and read data, checked by separate monitors.
`timescale 1ns/1ps
module tb_eth_transmitter;

    localparam logic [15:0] BUF = 16'hF000;
    localparam logic [15:0] CR  = 16'hFB00;
    localparam logic [15:0] ST  = 16'hFB01;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] a = 16'h0000;
    logic        n_we = 1'b1;
    logic        n_oe = 1'b1;
    logic [7:0]  tb_dat = 8'h00;
    logic        tb_drv = 1'b0;
    wire  [7:0]  d;
    wire         n_rdy, tx_sck, tx_mosi;

    assign d = tb_drv ? tb_dat : 8'bz;

    eth_transmitter #(.SCK_HALF(2)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .a       (a),
        .d       (d),
        .n_we    (n_we),
        .n_oe    (n_oe),
        .n_rdy   (n_rdy),
        .tx_sck  (tx_sck),
        .tx_mosi (tx_mosi)
    );

    always #12.5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         pulses = 0;
    int         base;
    logic [7:0] q_tx [$];
    logic [7:0] q_rd [$];
    logic       rd_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        int v;
        v = ((k & 255) + 1) * 239 + ((k >> 2) & 255) * 113;
        return 8'(v);
    endfunction

    // Serial receiver: samples mosi on each sck fall, LSB first.
    initial begin : ser_mon
        logic [7:0] sh;
        logic [7:0] e;
        int         nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(negedge tx_sck or negedge n_rst);
            if (!n_rst) begin
                nb = 0;
            end else begin
                pulses++;
                sh = {tx_mosi, sh[7:1]};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (q_tx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL serial_byte: got %02h, expected none", sh);
                    end else begin
                        e = q_tx.pop_front();
                        check("serial_byte", 32'(sh), 32'(e));
                    end
                end
            end
        end
    end

    // Read monitor: compares d when n_rdy falls during a read.
    initial begin : rd_mon
        logic       prev;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rd_active && prev && !n_rdy) begin
                if (q_rd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cpu_read: got %02h, expected none", d);
                end else begin
                    e = q_rd.pop_front();
                    check("cpu_read", 32'(d), 32'(e));
                end
            end
            prev = n_rdy;
        end
    end

    task automatic wait_rdy(input logic lvl, input int budget,
                            input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (n_rdy == lvl);
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] v);
        @(negedge clk);
        a = addr;
        tb_dat = v;
        tb_drv = 1'b1;
        n_we = 1'b0;
        wait_rdy(1'b0, 2, "wr_rdy_low");
        n_we = 1'b1;
        wait_rdy(1'b1, 1, "wr_rdy_high");
        tb_drv = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] addr, input logic [7:0] exp);
        @(negedge clk);
        rd_active = 1'b1;
        q_rd.push_back(exp);
        a = addr;
        n_oe = 1'b0;
        wait_rdy(1'b0, 2, "rd_rdy_low");
        n_oe = 1'b1;
        wait_rdy(1'b1, 1, "rd_rdy_high");
        rd_active = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget,
                               input string name);
        int c;
        c = 0;
        while (pulses < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(pulses), 32'(target));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(tx_sck), 32'd0);
        check("rst_mosi", 32'(tx_mosi), 32'd0);
        check("rst_rdy", 32'(n_rdy), 32'd1);
        n_rst = 1'b1;
        @(negedge clk);
        cpu_read(CR, 8'h00);
        base = pulses;
        repeat (400) @(negedge clk);
        check("idle_no_sck", 32'(pulses - base), 32'd0);

        // Unmapped address: no handshake at all.
        @(negedge clk);
        a = 16'hFB02;
        n_oe = 1'b0;
        repeat (4) @(negedge clk);
        check("unmapped_rdy", 32'(n_rdy), 32'd1);
        n_oe = 1'b1;
        repeat (2) @(negedge clk);

        // Full 1024-byte frame.
        for (int k = 0; k < 1024; k++) begin
            cpu_write(BUF + 16'(k), pat(k));
        end
        cpu_read(CR, 8'h00);
        cpu_read(BUF + 16'h03FF, pat(1023));
        cpu_read(BUF, pat(0));
        for (int k = 0; k < 1024; k++) begin
            q_tx.push_back(pat(k));
        end
        base = pulses;
        cpu_write(ST, 8'h5A);
        cpu_read(CR, 8'h02);
        wait_pulses(base + 8192, 40000, "frame1024_pulses");
        repeat (40) @(negedge clk);
        cpu_read(CR, 8'h00);
        check("frame1024_q_empty", 32'(q_tx.size()), 32'd0);
        repeat (200) @(negedge clk);
        check("frame1024_no_extra", 32'(pulses - base), 32'd8192);

        // Short three-byte frame.
        cpu_write(BUF + 16'd0, 8'hA5);
        cpu_write(BUF + 16'd1, 8'h01);
        cpu_write(BUF + 16'd2, 8'h80);
        q_tx.push_back(8'hA5);
        q_tx.push_back(8'h01);
        q_tx.push_back(8'h80);
        base = pulses;
        cpu_write(ST, 8'h00);
        wait_pulses(base + 24, 400, "frame3_pulses");
        repeat (100) @(negedge clk);
        check("frame3_exact", 32'(pulses - base), 32'd24);
        check("frame3_q_empty", 32'(q_tx.size()), 32'd0);
        cpu_read(CR, 8'h00);

        // Start with an empty buffer length.
        base = pulses;
        cpu_write(ST, 8'hFF);
        cpu_read(CR, 8'h00);
        repeat (200) @(negedge clk);
        check("len0_no_sck", 32'(pulses - base), 32'd0);

        // Restart while busy is ignored; buffer stays accessible.
        cpu_write(BUF + 16'd0, 8'h3C);
        cpu_write(BUF + 16'd1, 8'hC3);
        q_tx.push_back(8'h3C);
        q_tx.push_back(8'hC3);
        base = pulses;
        cpu_write(ST, 8'h01);
        cpu_read(CR, 8'h02);
        cpu_write(BUF + 16'd5, 8'h77);
        cpu_write(ST, 8'h01);
        cpu_read(BUF + 16'd0, 8'h3C);
        cpu_read(BUF + 16'd5, 8'h77);
        wait_pulses(base + 16, 400, "frame2_pulses");
        repeat (100) @(negedge clk);
        check("restart_ignored", 32'(pulses - base), 32'd16);
        check("frame2_q_empty", 32'(q_tx.size()), 32'd0);
        cpu_read(CR, 8'h00);

        // Reset in the middle of a frame.
        cpu_write(BUF + 16'd0, 8'h11);
        cpu_write(BUF + 16'd1, 8'h22);
        cpu_write(BUF + 16'd2, 8'h33);
        cpu_write(BUF + 16'd3, 8'h44);
        q_tx.push_back(8'h11);
        q_tx.push_back(8'h22);
        base = pulses;
        cpu_write(ST, 8'h00);
        wait_pulses(base + 10, 400, "abort_pre_pulses");
        for (int i = 0; i < 8 && !tx_sck; i++) begin
            @(negedge clk);
        end
        check("abort_sck_high", 32'(tx_sck), 32'd1);
        n_rst = 1'b0;
        #1;
        check("abort_sck_low", 32'(tx_sck), 32'd0);
        check("abort_rdy", 32'(n_rdy), 32'd1);
        q_tx.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        base = pulses;
        cpu_read(CR, 8'h00);
        repeat (200) @(negedge clk);
        check("abort_no_sck", 32'(pulses - base), 32'd0);
        check("rd_q_empty", 32'(q_rd.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_transmitter.md
# eth_transmitter

Memory-mapped Ethernet transmit path for the CPU bus. The CPU fills a 1 KiB frame buffer, then writes a start register. The block streams the buffered bytes out over a write-only SPI-style link (`tx_sck`/`tx_mosi`) to the external MAC/PHY. A status bit in the control register reports when the transmitter is busy.

## Interface
Parameters:
- `SCK_HALF` (default 2): `clk` cycles per `tx_sck` half-period; must be ≥ 1.
- `BUF_BASE` (default 16'hF000): base address of the 1024-byte buffer.
- `CR_ADDR` (default 16'hFB00): control/status register.
- `TX_RST_ADDR` (default 16'hFB01): transmit-start strobe register.

Ports:
- `clk` in 1: the single clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `a` in 16: CPU address.
- `d` inout 8: CPU data. Driven only during a selected read; high-Z otherwise.
- `n_we` in 1: active-low write strobe.
- `n_oe` in 1: active-low read strobe.
- `n_rdy` out 1: active-low access-complete signal. It is 1 when no selected access is in progress.
- `tx_sck` out 1: serial clock. Idles low.
- `tx_mosi` out 1: serial data, LSB first.

## Operation
**Address decode**
- A selected access is one where `a` is in `BUF_BASE..BUF_BASE+0x3FF`, or `a` equals `CR_ADDR` or `TX_RST_ADDR`. All other addresses are ignored: `d` stays high-Z and `n_rdy` stays 1.

**Buffer accesses**
- Write: stores `d` at offset `a[9:0]` and updates `len = max(len, a[9:0]+1)`. `len` is 11 bits, range 0..1024.
- Read: returns the stored byte.

**Control register (`CR_ADDR`)**
- Read returns `{6'b0, busy, 1'b0}`. Bit 1 is TX_N_RDY: 1 while a frame is transmitting.
- Writes are ignored.

**Start strobe (`TX_RST_ADDR`)**
- A write with any data value, while idle and with `len` ≠ 0: sets `busy`, latches the frame length, clears `len` to 0, and resets the read pointer to offset 0.
- Ignored while busy, or when `len` = 0.

**Transmit FSM**
- States: IDLE → LOAD (fetch byte at pointer) → SHIFT (8 bits) → LOAD, or → IDLE after the last byte.
- `busy` clears on entering IDLE.

**Serial bit sequence**
- Per bit: set `tx_mosi` to the current bit (bit 0 first). Hold `tx_sck` low for `SCK_HALF` clocks, then high for `SCK_HALF` clocks, then drive it low.
- The receiver samples on the falling edge of `tx_sck`. `tx_mosi` must not change until at least one clock after that falling edge.
- Exactly 8×length `tx_sck` pulses are produced per frame; there is no further `tx_sck` activity until the next start.

**Arbitration**
- CPU buffer accesses take priority over the LOAD fetch. A fetch that collides with a CPU access is retried the next cycle.
- CPU buffer writes during transmission are permitted and take effect immediately.

## Timing
**Reset values**
- `busy`=0, `len`=0, pointer=0, `tx_sck`=0, `tx_mosi`=0, `n_rdy`=1, `d`=Z.
- Reset mid-frame aborts the frame immediately and returns to these values.

**CPU handshake**
- Strobes are sampled on `clk`.
- `n_rdy` goes low at most 2 clocks after a selected strobe falls, and stays low while the strobe is held.
- For reads, `d` is valid when `n_rdy` goes low.
- A write completes when `n_rdy` is low. The write effect (buffer, `len`, start) is committed before `n_rdy` goes low.
- `n_rdy` returns to 1 one clock after both strobes are high.

**Transmit timing**
- `busy` reads 1 from the clock after the start write through the last falling edge of `tx_sck`.
- `busy` clears ≤ 2 clocks after the last falling edge of `tx_sck`.
- First `tx_sck` rise occurs ≤ `SCK_HALF`+3 clocks after start.
- Inter-byte gap is ≤ 3 clocks.
- With `clk` ≥ 40 MHz and `SCK_HALF`=2, a 1024-byte frame completes in < 1 ms.

## Structure
- Shared package `eth_pkg`: address constants, CR bit index `CR_TX_N_RDY_BIT`=1, buffer size 1024.
- Sub-module `eth_tx_shifter`: loads a byte, shifts it out LSB-first, generates `tx_sck`, and pulses `done`.
- Top level contains: 1024×8 single-port RAM, bus decode and handshake, `len`/pointer counters, and the FSM.

## Test plan
- Reset → `tx_sck`=0; CR read = 0x00; no `tx_sck` activity within 10 µs.
- Write offset k = `((k[7:0]+1)*239 + k[9:2]*113) mod 256` for k=0..1023 → CR bit1 = 0. Write 0xFB01 → CR bit1 = 1 within 1 µs. All 1024 bytes received LSB-first in order with matching values. CR bit1 = 0 about 1 µs after the last bit. No extra `tx_sck` pulse afterwards.
- Write 3 bytes (0xA5, 0x01, 0x80) at offsets 0..2, then start → exactly 24 `tx_sck` pulses; the receiver gets A5 01 80.
- Start with `len`=0 → no `tx_sck` pulses; CR bit1 stays 0.
- Second start written while busy → ignored; the frame length is unchanged. Buffer read during transmission returns the written data.
- Assert `n_rst` mid-frame → `tx_sck` low immediately; CR = 0x00 after release.
